hex_display_queue: RTL and testbench

- Output stage directly downstream of the 8-bit microprocessor core; consumes the core's register write-back data (REG_WRITE_DATA plus write strobe).
- Buffers write-back values in a small FIFO and drives them, one at a time, onto the two seven-segment displays DIS1 (high nibble) and DIS2 (low nibble).
- Each value stays on the displays for a fixed number of cycles, so fast write bursts remain observable on the board and in simulation.

---
 rtl/hex_display_queue.sv | 166 ++++++++++++++++
 tb/tb_hex_display_queue.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_queue.sv
// Queues core write-back bytes and shows each on two seven-segment digits for HOLD_CYCLES cycles.
// Build option: HEX_DISPLAY_QUEUE_LEADING_ZERO_BLANK_EN blanks DIS1 when the high nibble is zero.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// SHOW_IDLE | nothing being timed; pops the FIFO head as soon as one exists
// SHOW_HOLD | a value is on the displays; hold_cnt counts down to 0
module hex_display_queue #(
  parameter int HOLD_CYCLES = 16,
  parameter int DEPTH       = 4,
  parameter int DEPTH_LOG2  = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WR_EN,
  input  logic [7:0]            WR_DATA,
  output logic [6:0]            DIS1,
  output logic [6:0]            DIS2,
  output logic [7:0]            VALUE,
  output logic                  BUSY,
  output logic [DEPTH_LOG2:0]   PENDING,
  output logic                  OVF
);

  localparam int CW = $clog2(HOLD_CYCLES) + 1;

  localparam logic [0:0] SHOW_IDLE = 1'b0;
  localparam logic [0:0] SHOW_HOLD = 1'b1;

  localparam logic [CW-1:0]         HOLD_LOAD  = CW'(HOLD_CYCLES - 1);
  localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [6:0]            SEG_BLANK  = 7'h7F;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level;
  logic [CW-1:0]         hold_cnt;
  logic [0:0]            state;
  logic                  ovf_q;
  logic [7:0]            value_q;
  logic [6:0]            dis1_q;
  logic [6:0]            dis2_q;

  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  hold_done;
  logic                  pop;
  logic                  push;
  logic                  drop;
  logic [7:0]            head;
  logic [6:0]            head_hi_seg;
  logic [6:0]            head_lo_seg;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == FULL_LEVEL);
  assign hold_done  = (state == SHOW_HOLD) && (hold_cnt == '0);

  // A full FIFO still accepts a write on the edge that frees a slot by popping.
  assign pop  = !fifo_empty && ((state == SHOW_IDLE) || hold_done);
  assign push = WR_EN && (!fifo_full || pop);
  assign drop = WR_EN && fifo_full && !pop;

  assign head        = mem[rd_ptr];
  assign head_lo_seg = seg7(head[3:0]);

`ifdef HEX_DISPLAY_QUEUE_LEADING_ZERO_BLANK_EN
  assign head_hi_seg = (head[7:4] == 4'h0) ? SEG_BLANK : seg7(head[7:4]);
`else
  assign head_hi_seg = seg7(head[7:4]);
`endif

  // Storage array carries no reset; only the pointers and level define validity.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= WR_DATA;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + (DEPTH_LOG2 + 1)'(1);
        2'b01:   level <= level - (DEPTH_LOG2 + 1)'(1);
        default: level <= level;
      endcase
      if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= SHOW_IDLE;
      hold_cnt <= '0;
      value_q  <= '0;
      dis1_q   <= SEG_BLANK;
      dis2_q   <= SEG_BLANK;
    end else begin
      if (pop) begin
        value_q  <= head;
        dis1_q   <= head_hi_seg;
        dis2_q   <= head_lo_seg;
        hold_cnt <= HOLD_LOAD;
        state    <= SHOW_HOLD;
      end else begin
        case (state)
          SHOW_HOLD: begin
            if (hold_cnt != '0) begin
              hold_cnt <= hold_cnt - CW'(1);
            end else begin
              state <= SHOW_IDLE;
            end
          end
          default: begin
            state    <= SHOW_IDLE;
            hold_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign DIS1    = dis1_q;
  assign DIS2    = dis2_q;
  assign VALUE   = value_q;
  assign BUSY    = (state == SHOW_HOLD);
  assign PENDING = level;
  assign OVF     = ovf_q;

endmodule

// File: tb/tb_hex_display_queue.sv
// Bench for hex_display_queue: directed and random writes against a display-schedule model.
// Honors HEX_DISPLAY_QUEUE_LEADING_ZERO_BLANK_EN to match the DUT build.
module tb_hex_display_queue;

  localparam int HOLD  = 4;
  localparam int DEPTH = 4;

  logic       CLK;
  logic       RST;
  logic       WR_EN;
  logic [7:0] WR_DATA;
  logic [6:0] DIS1;
  logic [6:0] DIS2;
  logic [7:0] VALUE;
  logic       BUSY;
  logic [2:0] PENDING;
  logic       OVF;

  int checks = 0;
  int errors = 0;

  // Model: each accepted write gets a display start edge; everything else derives from that list.
  int e = 0;
  int q_val[$];
  int q_wr[$];
  int q_start[$];
  bit ovf_m = 0;

  hex_display_queue #(
    .HOLD_CYCLES(HOLD),
    .DEPTH(DEPTH),
    .DEPTH_LOG2(2)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .WR_EN(WR_EN),
    .WR_DATA(WR_DATA),
    .DIS1(DIS1),
    .DIS2(DIS2),
    .VALUE(VALUE),
    .BUSY(BUSY),
    .PENDING(PENDING),
    .OVF(OVF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [6:0] seg_ref(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  function automatic void model_clear();
    e = 0;
    ovf_m = 0;
    q_val.delete();
    q_wr.delete();
    q_start.delete();
  endfunction

  // Called after edge e with the inputs that edge sampled.
  function automatic void model_edge(input bit wr, input logic [7:0] d);
    int pend;
    bit pop_now;
    int s;
    pend = 0;
    pop_now = 0;
    if (wr) begin
      foreach (q_start[i]) begin
        if (q_wr[i] < e && q_start[i] >= e) pend++;
        if (q_start[i] == e) pop_now = 1;
      end
      if (pend == DEPTH && !pop_now) begin
        ovf_m = 1;
      end else begin
        s = e + 1;
        if (q_start.size() > 0 && q_start[$] + HOLD > s) s = q_start[$] + HOLD;
        q_val.push_back(int'(d));
        q_wr.push_back(e);
        q_start.push_back(s);
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, e, obs, exp);
    end
  endtask

  task automatic check_all();
    int idx;
    int pend;
    logic [7:0] v;
    logic [6:0] d1;
    logic [6:0] d2;
    bit busy;
    idx = -1;
    pend = 0;
    foreach (q_start[i]) begin
      if (q_start[i] <= e) idx = i;
      if (q_wr[i] <= e && q_start[i] > e) pend++;
    end
    if (idx < 0) begin
      v = 8'h00;
      d1 = 7'h7F;
      d2 = 7'h7F;
      busy = 0;
    end else begin
      v = q_val[idx][7:0];
      d2 = seg_ref(v[3:0]);
`ifdef HEX_DISPLAY_QUEUE_LEADING_ZERO_BLANK_EN
      d1 = (v[7:4] == 4'h0) ? 7'h7F : seg_ref(v[7:4]);
`else
      d1 = seg_ref(v[7:4]);
`endif
      busy = (e < q_start[idx] + HOLD);
    end
    chk("VALUE", 32'(VALUE), 32'(v));
    chk("DIS1", 32'(DIS1), 32'(d1));
    chk("DIS2", 32'(DIS2), 32'(d2));
    chk("BUSY", 32'(BUSY), 32'(busy));
    chk("PENDING", 32'(PENDING), 32'(pend));
    chk("OVF", 32'(OVF), 32'(ovf_m));
  endtask

  task automatic step(input bit wr, input logic [7:0] d);
    WR_EN = wr;
    WR_DATA = d;
    @(posedge CLK);
    e++;
    model_edge(wr, d);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic do_reset(input int n);
    RST = 1'b1;
    WR_EN = 1'b0;
    model_clear();
    #1;
    check_all();
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      check_all();
    end
    RST = 1'b0;
  endtask

  initial begin
    int rate;
    RST = 1'b1;
    WR_EN = 1'b0;
    WR_DATA = 8'h00;

    do_reset(5);

    // Single write: shows on the 2nd edge, held HOLD cycles, then retained.
    step(1'b1, 8'h3A);
    step(1'b0, 8'h00);
    chk("first_dis1_3A", 32'(DIS1), 32'h30);
    chk("first_dis2_3A", 32'(DIS2), 32'h08);
    idle(10);
    chk("held_value_3A", 32'(VALUE), 32'h3A);

    // Back-to-back writes drain with no idle gap.
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i));
    idle(20);

    // Overflow: seventh write is dropped; the full push+pop edge keeps OVF low.
    do_reset(2);
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h10 + i));
    chk("ovf_set", 32'(OVF), 32'h1);
    idle(30);
    chk("ovf_sticky", 32'(OVF), 32'h1);
    chk("last_shown_15", 32'(VALUE), 32'h15);

    // Reset asserted mid-hold takes effect before the next edge.
    step(1'b1, 8'hC7);
    idle(2);
    RST = 1'b1;
    WR_EN = 1'b0;
    model_clear();
    #1;
    check_all();
    do_reset(1);

    // Leading-zero value.
    step(1'b1, 8'h05);
    idle(6);

    // Random traffic at varying write densities.
    for (int blk = 0; blk < 8; blk++) begin
      rate = (blk % 4 == 0) ? 10 : (blk % 4 == 1) ? 45 : (blk % 4 == 2) ? 90 : 25;
      for (int i = 0; i < 50; i++) begin
        step($urandom_range(0, 99) < rate, 8'($urandom_range(0, 255)));
      end
      if (blk == 4) do_reset(2);
    end
    idle(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
